spi_rx_deser: RTL

- Downstream consumer of the SPI MOSI transmit stage. It receives spi_mosi_out, spi_clk and spi_cs in the m_clk domain and oversamples them.
- It deserialises each 8-bit frame, MSB first, and buffers completed bytes in a small first-word-fall-through FIFO for the host to read.
- It is used as the on-chip loopback checker and as the receive front end of the full SPI link.

---
 rtl/spi_pkg.sv | 12 +
 rtl/rx_sync_fifo.sv | 49 ++++
 rtl/spi_rx_deser.sv | 134 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI receive path: word width, chip-select polarity
// and the deserialiser state encoding.
package spi_pkg;

  localparam int unsigned SPI_DATA_W    = 8;
  localparam logic        SPI_CS_ACTIVE = 1'b0;

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with a fall-through head; the pointers carry one extra
// wrap bit so full and empty can be told apart.
module rx_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_c,
  output logic              empty_c,
  output logic              full_c,
  output logic              ovf_evt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop    = pop && !empty_c;
  // A pop in the same cycle frees the slot being written, so a full push still lands.
  assign do_push   = push && (!full_c || do_pop);
  assign ovf_evt_c = push && full_c && !do_pop;
  assign head_c    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/spi_rx_deser.sv
// Oversampling SPI mode-0 receiver: synchronises the serial inputs into m_clk,
// deserialises MSB-first words and queues them in a small receive FIFO.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = SPI_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic        CS_ACTIVE  = SPI_CS_ACTIVE
) (
  input  logic              m_clk,
  input  logic              n_reset,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              fifo_full,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clr_status
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic s1_clk, s2_clk, s3_clk;
  logic s1_cs, s2_cs;
  logic s1_mosi, s2_mosi;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-2:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_err_d;
  logic              push_c;
  logic              push_q;
  logic [DATA_W-1:0] push_data_q;
  logic              rise_c;
  logic              cs_act_c;
  logic              last_rise_c;
  logic              empty_c;
  logic              ovf_evt_c;

  // Two-flop synchronisers; spi_clk gets a third stage for edge detection.
  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      {s1_clk, s2_clk, s3_clk} <= '0;
      {s1_cs, s2_cs}           <= '0;
      {s1_mosi, s2_mosi}       <= '0;
    end else begin
      {s1_clk, s2_clk, s3_clk} <= {spi_clk, s1_clk, s2_clk};
      {s1_cs, s2_cs}           <= {spi_cs, s1_cs};
      {s1_mosi, s2_mosi}       <= {spi_mosi_in, s1_mosi};
    end
  end

  assign rise_c      = s2_clk && !s3_clk;
  assign cs_act_c    = (s2_cs == CS_ACTIVE);
  assign last_rise_c = rise_c && (cnt_q == LAST_BIT);

  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_WAIT_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      frame_err   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      frame_err   <= frame_err_d;
      push_q      <= push_c;
      push_data_q <= {sr_q, s2_mosi};
    end
  end

  // sr_q holds only the DATA_W-1 bits already shifted; the live bit completes the word.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
    case (state_q)
      ST_WAIT_IDLE: begin
        if (!cs_act_c) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (cs_act_c) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (rise_c) begin
          sr_d  = {sr_q[DATA_W-3:0], s2_mosi};
          cnt_d = last_rise_c ? '0 : cnt_q + CNT_W'(1);
          push_c = last_rise_c;
        end
        if (!cs_act_c) begin
          frame_err_d = (cnt_q != '0) && !last_rise_c;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  rx_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (m_clk),
    .rst_n     (n_reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (rd_en),
    .head_c    (rd_data),
    .empty_c   (empty_c),
    .full_c    (fifo_full),
    .ovf_evt_c (ovf_evt_c)
  );

  assign rd_valid = !empty_c;

  // A fresh drop outranks a clear in the same cycle.
  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset)        overflow <= 1'b0;
    else if (ovf_evt_c)  overflow <= 1'b1;
    else if (clr_status) overflow <= 1'b0;
  end

endmodule
